// File: rtl/rv_gpio_pkg.sv
// Shared definitions for the rv_gpio peripheral: register offsets, register
// select encoding and the byte-lane write mask helper.
package rv_gpio_pkg;

  localparam logic [4:0] GPIO_IN    = 5'h00;
  localparam logic [4:0] GPIO_OUT   = 5'h04;
  localparam logic [4:0] GPIO_SET   = 5'h08;
  localparam logic [4:0] GPIO_CLR   = 5'h0C;
  localparam logic [4:0] GPIO_DIR   = 5'h10;
  localparam logic [4:0] GPIO_IEN   = 5'h14;
  localparam logic [4:0] GPIO_IMODE = 5'h18;
  localparam logic [4:0] GPIO_ISTAT = 5'h1C;

  // Select values are the word index of each offset (adr[4:2]).
  typedef enum logic [2:0] {
    SEL_IN    = GPIO_IN[4:2],
    SEL_OUT   = GPIO_OUT[4:2],
    SEL_SET   = GPIO_SET[4:2],
    SEL_CLR   = GPIO_CLR[4:2],
    SEL_DIR   = GPIO_DIR[4:2],
    SEL_IEN   = GPIO_IEN[4:2],
    SEL_IMODE = GPIO_IMODE[4:2],
    SEL_ISTAT = GPIO_ISTAT[4:2]
  } gpio_sel_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    logic [31:0] m;
    m = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{we[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rv_sync.sv
// Multi-stage flop synchroniser for asynchronous inputs, synchronous reset to 0.
module rv_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rv_gpio.sv
// Parametrised GPIO port on the rv_core data bus: direction, set/clear writes,
// synchronised inputs and per-bit rising/falling edge interrupts.
module rv_gpio
  import rv_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       adr,
  input  logic             cs,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [31:0]      dw,
  output logic [31:0]      dr,
  input  logic             rdy,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic [WIDTH-1:0] poe,
  output logic             irq
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] imode_q, imode_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      dr_q, dr_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] wdat, wmsk, w1c, edge_det;
  logic [31:0]      wmask_full;
  logic             wr_en, rd_en, settled;
  gpio_sel_e        sel;
  logic             unused_bits;

  rv_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pin),
    .q_o   (sync_s)
  );

  assign sel        = gpio_sel_e'(adr[4:2]);
  assign wr_en      = cs & rdy & (|we);
  assign rd_en      = cs & re & rdy;
  assign wmask_full = lane_mask(we);
  assign wmsk       = wmask_full[WIDTH-1:0];
  assign wdat       = dw[WIDTH-1:0];
  assign settled    = (cnt_q == CW'(SETTLE));
  assign unused_bits = ^{adr[1:0], dw, wmask_full};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [WIDTH-1:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    imode_d = imode_q;
    w1c     = '0;
    if (wr_en) begin
      case (sel)
        SEL_OUT:   out_d   = merge(out_q, wdat, wmsk);
        SEL_SET:   out_d   = out_q | (wdat & wmsk);
        SEL_CLR:   out_d   = out_q & ~(wdat & wmsk);
        SEL_DIR:   dir_d   = merge(dir_q, wdat, wmsk);
        SEL_IEN:   ien_d   = merge(ien_q, wdat, wmsk);
        SEL_IMODE: imode_d = merge(imode_q, wdat, wmsk);
        SEL_ISTAT: w1c     = wdat & wmsk;
        default:   ;
      endcase
    end
  end

  // Edge sources are gated until the synchroniser has flushed its reset zeros.
  always_comb begin
    edge_det = '0;
    if (settled) begin
      edge_det = ((sync_s & ~prev_q) & ~imode_q) | ((~sync_s & prev_q) & imode_q);
    end
    stat_d = (stat_q & ~w1c) | edge_det;
    cnt_d  = settled ? cnt_q : cnt_q + CW'(1);
    irq_d  = |(stat_q & ien_q);
  end

  always_comb begin
    dr_d = '0;
    if (rd_en) begin
      case (sel)
        SEL_IN:    dr_d[WIDTH-1:0] = sync_s;
        SEL_OUT:   dr_d[WIDTH-1:0] = out_q;
        SEL_DIR:   dr_d[WIDTH-1:0] = dir_q;
        SEL_IEN:   dr_d[WIDTH-1:0] = ien_q;
        SEL_IMODE: dr_d[WIDTH-1:0] = imode_q;
        SEL_ISTAT: dr_d[WIDTH-1:0] = stat_q;
        default:   dr_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      imode_q <= '0;
      stat_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      dr_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      imode_q <= imode_d;
      stat_q  <= stat_d;
      prev_q  <= sync_s;
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      irq_q   <= irq_d;
    end
  end

  assign pout = out_q;
  assign poe  = dir_q;
  assign dr   = dr_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_rv_gpio.sv
// Directed scoreboard bench for rv_gpio: an 8-bit and a 32-bit instance share
// the bus; expected outputs are queued per cycle and checked by a monitor.
module tb_rv_gpio;
  import rv_gpio_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  adr;
  logic        cs;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic        rdy;
  logic [7:0]  pin8, pout8, poe8;
  logic [31:0] pin32, pout32, poe32;
  logic [31:0] dr8, dr32;
  logic        irq8, irq32;

  typedef enum {S_POUT8, S_POE8, S_IRQ8, S_DR8, S_POUT32, S_POE32, S_DR32} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  rv_gpio #(.WIDTH(8), .SYNC_STAGES(2), .SETTLE(4)) u8 (
    .clk(clk), .reset(reset), .adr(adr), .cs(cs), .we(we), .re(re), .dw(dw),
    .dr(dr8), .rdy(rdy), .pin(pin8), .pout(pout8), .poe(poe8), .irq(irq8)
  );

  rv_gpio #(.WIDTH(32), .SYNC_STAGES(2), .SETTLE(4)) u32 (
    .clk(clk), .reset(reset), .adr(adr), .cs(cs), .we(we), .re(re), .dw(dw),
    .dr(dr32), .rdy(rdy), .pin(pin32), .pout(pout32), .poe(poe32), .irq(irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_POUT8:  return {24'h0, pout8};
      S_POE8:   return {24'h0, poe8};
      S_IRQ8:   return {31'h0, irq8};
      S_DR8:    return dr8;
      S_POUT32: return pout32;
      S_POE32:  return poe32;
      S_DR32:   return dr32;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic void sb_push(input int c, input sig_e s, input logic [31:0] e, input string n);
    item_t it;
    it.cyc = c; it.sig = s; it.exp = e; it.name = n;
    sb.push_back(it);
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = sample(sb[i].sig);
        n_checks++;
        if (sb[i].cyc < cyc || act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s (cycle %0d, now %0d): got %h expected %h",
                   sb[i].name, sb[i].cyc, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] w, input logic [31:0] d);
    adr = a; we = w; dw = d; cs = 1'b1; re = 1'b0;
    tick;
    cs = 1'b0; we = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e8, input logic [31:0] e32,
                    input string n, input bit trail);
    adr = a; cs = 1'b1; re = 1'b1; we = '0;
    sb_push(cyc + 1, S_DR8, e8, {n, "_dr8"});
    sb_push(cyc + 1, S_DR32, e32, {n, "_dr32"});
    if (trail) begin
      sb_push(cyc + 2, S_DR8, 32'h0, {n, "_idle_dr8"});
      sb_push(cyc + 2, S_DR32, 32'h0, {n, "_idle_dr32"});
    end
    tick;
    cs = 1'b0; re = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1; cs = 1'b0; re = 1'b0; we = '0; adr = '0; dw = '0; rdy = 1'b1;
    pin8 = 8'hFF; pin32 = '0;
    tick; tick; tick;
    n_checks++;
    if (pout8 !== 8'h00 || poe8 !== 8'h00) begin
      n_fail++;
      $display("FAIL direct_rst_8: pout8=%h poe8=%h expected 00", pout8, poe8);
    end
    n_checks++;
    if (pout32 !== 32'h0 || poe32 !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_rst_32: pout32=%h poe32=%h expected 0", pout32, poe32);
    end
    n_checks++;
    if (irq8 !== 1'b0 || irq32 !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_rst_irq: irq8=%b irq32=%b expected 0", irq8, irq32);
    end
    sb_push(cyc, S_POUT8, 32'h0, "rst_pout8");
    sb_push(cyc, S_POE8, 32'h0, "rst_poe8");
    sb_push(cyc, S_IRQ8, 32'h0, "rst_irq8");
    sb_push(cyc, S_DR8, 32'h0, "rst_dr8");
    sb_push(cyc, S_POUT32, 32'h0, "rst_pout32");
    reset = 1'b0;
    tick;

    // pin held high through reset: IN appears after the synchroniser depth
    rd(GPIO_IN, 32'h00, 32'h0, "in_early", 1'b0);
    rd(GPIO_IN, 32'hFF, 32'h0, "in_sync", 1'b1);

    wr(GPIO_OUT, 4'b0001, 32'h0000_00A5);
    sb_push(cyc, S_POUT8, 32'hA5, "out_wr"); sb_push(cyc, S_POUT32, 32'hA5, "out_wr32");
    wr(GPIO_SET, 4'b0001, 32'h0000_000A);
    sb_push(cyc, S_POUT8, 32'hAF, "out_set"); sb_push(cyc, S_POUT32, 32'hAF, "out_set32");
    wr(GPIO_CLR, 4'b0001, 32'h0000_0081);
    sb_push(cyc, S_POUT8, 32'h2E, "out_clr"); sb_push(cyc, S_POUT32, 32'h2E, "out_clr32");
    wr(GPIO_OUT, 4'b0010, 32'h0000_FF00);
    sb_push(cyc, S_POUT8, 32'h2E, "out_lane1"); sb_push(cyc, S_POUT32, 32'hFF2E, "out_lane1_32");
    wr(GPIO_DIR, 4'b0001, 32'h0000_00F0);
    sb_push(cyc, S_POE8, 32'hF0, "dir_wr"); sb_push(cyc, S_POE32, 32'hF0, "dir_wr32");
    rd(GPIO_OUT, 32'h2E, 32'hFF2E, "rd_out", 1'b0);
    rd(GPIO_SET, 32'h0, 32'h0, "rd_set_wo", 1'b0);
    repeat (14) tick;
    rd(GPIO_ISTAT, 32'h0, 32'h0, "istat_settle", 1'b0);

    // rising edge on bit 0
    pin8 = 8'h00;
    repeat (4) tick;
    wr(GPIO_IEN, 4'b0001, 32'h01);
    c = cyc;
    pin8 = 8'h01;
    sb_push(c + 3, S_IRQ8, 32'h0, "irq_before");
    sb_push(c + 4, S_IRQ8, 32'h1, "irq_rise");
    tick; tick;
    rd(GPIO_ISTAT, 32'h00, 32'h0, "istat_pre_edge", 1'b0);
    rd(GPIO_ISTAT, 32'h01, 32'h0, "istat_rise", 1'b0);
    wr(GPIO_ISTAT, 4'b0001, 32'h01);
    sb_push(cyc, S_IRQ8, 32'h1, "irq_w1c_hold");
    sb_push(cyc + 1, S_IRQ8, 32'h0, "irq_w1c_clear");

    // falling-edge mode on bit 1
    wr(GPIO_IMODE, 4'b0001, 32'h02);
    wr(GPIO_IEN, 4'b0001, 32'h02);
    pin8 = 8'h03;
    repeat (5) tick;
    sb_push(cyc, S_IRQ8, 32'h0, "irq_fall_mode_rise");
    rd(GPIO_ISTAT, 32'h00, 32'h0, "istat_fall_mode_rise", 1'b0);
    pin8 = 8'h01;
    repeat (5) tick;
    sb_push(cyc, S_IRQ8, 32'h1, "irq_fall");
    rd(GPIO_ISTAT, 32'h02, 32'h0, "istat_fall", 1'b0);
    pin8 = 8'h03;
    repeat (5) tick;
    rd(GPIO_ISTAT, 32'h02, 32'h0, "istat_fall_then_rise", 1'b0);
    wr(GPIO_ISTAT, 4'b0001, 32'h02);
    sb_push(cyc + 1, S_IRQ8, 32'h0, "irq_fall_clear");
    rd(GPIO_ISTAT, 32'h00, 32'h0, "istat_fall_clear", 1'b0);

    // W1C colliding with a fresh edge on the same bit
    wr(GPIO_IEN, 4'b0001, 32'h01);
    pin8 = 8'h02;
    repeat (4) tick;
    pin8 = 8'h03;
    repeat (5) tick;
    sb_push(cyc, S_IRQ8, 32'h1, "irq_setup");
    pin8 = 8'h02;
    repeat (4) tick;
    pin8 = 8'h03;
    tick; tick;
    wr(GPIO_ISTAT, 4'b0001, 32'h01);
    sb_push(cyc, S_IRQ8, 32'h1, "irq_collide0");
    sb_push(cyc + 1, S_IRQ8, 32'h1, "irq_collide1");
    sb_push(cyc + 2, S_IRQ8, 32'h1, "irq_collide2");
    rd(GPIO_ISTAT, 32'h01, 32'h0, "istat_collide", 1'b0);
    wr(GPIO_ISTAT, 4'b0001, 32'h01);
    sb_push(cyc + 1, S_IRQ8, 32'h0, "irq_collide_clear");

    // upper byte lanes on the 32-bit instance
    wr(GPIO_CLR, 4'b1111, 32'hFFFF_FFFF);
    sb_push(cyc, S_POUT8, 32'h0, "clr_all"); sb_push(cyc, S_POUT32, 32'h0, "clr_all32");
    wr(GPIO_OUT, 4'b1100, 32'h1234_5678);
    sb_push(cyc, S_POUT8, 32'h0, "out_hi_lanes8");
    sb_push(cyc, S_POUT32, 32'h1234_0000, "out_hi_lanes32");
    rd(GPIO_OUT, 32'h0, 32'h1234_0000, "rd_out_hi", 1'b0);

    // reset asserted during a read
    adr = GPIO_OUT; cs = 1'b1; re = 1'b1; reset = 1'b1;
    tick;
    cs = 1'b0; re = 1'b0; reset = 1'b0;
    sb_push(cyc, S_DR8, 32'h0, "rst_rd_dr8");
    sb_push(cyc, S_DR32, 32'h0, "rst_rd_dr32");
    sb_push(cyc, S_POUT32, 32'h0, "rst_rd_pout32");
    sb_push(cyc, S_POE8, 32'h0, "rst_rd_poe8");
    rd(GPIO_OUT, 32'h0, 32'h0, "post_rst_out", 1'b0);
    rd(GPIO_DIR, 32'h0, 32'h0, "post_rst_dir", 1'b0);
    rd(GPIO_IEN, 32'h0, 32'h0, "post_rst_ien", 1'b0);
    rd(GPIO_IMODE, 32'h0, 32'h0, "post_rst_imode", 1'b0);
    rd(GPIO_ISTAT, 32'h0, 32'h0, "post_rst_istat", 1'b1);
    repeat (4) tick;

    n_checks++;
    if (pout8 !== 8'h00 || pout32 !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_end_pout: pout8=%h pout32=%h expected 0", pout8, pout32);
    end
    n_checks++;
    if (dr8 !== 32'h0 || dr32 !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_end_dr: dr8=%h dr32=%h expected 0", dr8, dr32);
    end
    n_checks++;
    if (irq8 !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_end_irq8: irq8=%b expected 0", irq8);
    end

    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never compared (due cycle %0d) expected %h", it.name, it.cyc, it.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
